// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the 5-stage MIPS core: register-write metadata
// slots and the forwarding-mux select encoding.
package mips_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_MEMWB   = 2'd1;
    localparam logic [1:0] FWD_EXMEM   = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } pipe_slot_t;

    localparam pipe_slot_t BUBBLE = '0;

    // True when a slot will write a non-zero register matching src.
    function automatic logic slot_hits(
        input logic                  valid,
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] dest,
        input logic [REG_ADDR_W-1:0] src
    );
        return valid & reg_write & (dest != '0) & (dest == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one ALU operand: picks EX/MEM over MEM/WB over the
// register file for the given source register.
module fwd_select
    import mips_pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_src,
    input  pipe_slot_t            i_mem_slot,
    input  pipe_slot_t            i_wb_slot,
    output logic [1:0]            o_sel
);

    // Source fields of the older slots are carried for the pipeline, not needed here.
    logic w_unused;
    assign w_unused = ^{i_mem_slot.rs, i_mem_slot.rt, i_mem_slot.mem_read,
                        i_wb_slot.rs, i_wb_slot.rt, i_wb_slot.mem_read};

    always_comb begin
        // NOTE: default first so every path assigns o_sel and no latch is inferred.
        o_sel = FWD_REGFILE;
        if (slot_hits(i_mem_slot.valid, i_mem_slot.reg_write, i_mem_slot.dest, i_src)) begin
            o_sel = FWD_EXMEM;
        end else if (slot_hits(i_wb_slot.valid, i_wb_slot.reg_write, i_wb_slot.dest, i_src)) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and ALU operand forwarding for the MIPS pipeline.
// Optional same-cycle writeback bypass flags are enabled by HAZARD_WB_BYPASS_EN.
module hazard_forward_unit
    import mips_pipe_pkg::pipe_slot_t, mips_pipe_pkg::BUBBLE, mips_pipe_pkg::slot_hits;
#(
    parameter int REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic [REG_ADDR_W-1:0] i_id_dest,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_mem_read,
    input  logic                  i_flush,
    output logic [1:0]            o_forward_a,
    output logic [1:0]            o_forward_b,
    output logic                  o_stall,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic [CNT_W-1:0]      o_stall_count
`ifdef HAZARD_WB_BYPASS_EN
    ,
    output logic                  o_id_bypass_a,
    output logic                  o_id_bypass_b
`endif
);

    pipe_slot_t       r_ex;
    pipe_slot_t       r_mem;
    pipe_slot_t       r_wb;
    logic [CNT_W-1:0] r_stall_count;

    logic w_hazard;
    logic w_stall;

    assign w_hazard = i_id_valid & r_ex.valid & r_ex.mem_read & r_ex.reg_write
                    & (r_ex.dest != '0)
                    & ((r_ex.dest == i_id_rs) | (r_ex.dest == i_id_rt));

    // A taken branch discards the ID instruction, so it cannot also stall.
    assign w_stall = w_hazard & ~i_flush;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // NOTE: non-blocking so every slot shifts from pre-edge values in parallel.
            r_ex          <= BUBBLE;
            r_mem         <= BUBBLE;
            r_wb          <= BUBBLE;
            r_stall_count <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_stall || i_flush || !i_id_valid) begin
                r_ex <= BUBBLE;
            end else begin
                r_ex <= '{valid:     1'b1,
                          rs:        i_id_rs,
                          rt:        i_id_rt,
                          dest:      i_id_dest,
                          reg_write: i_id_reg_write,
                          mem_read:  i_id_mem_read};
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    fwd_select u_fwd_a (
        .i_src      (r_ex.rs),
        .i_mem_slot (r_mem),
        .i_wb_slot  (r_wb),
        .o_sel      (o_forward_a)
    );

    fwd_select u_fwd_b (
        .i_src      (r_ex.rt),
        .i_mem_slot (r_mem),
        .i_wb_slot  (r_wb),
        .o_sel      (o_forward_b)
    );

    assign o_stall       = w_stall;
    assign o_pc_write    = ~w_stall;
    assign o_ifid_write  = ~w_stall;
    assign o_stall_count = r_stall_count;

`ifdef HAZARD_WB_BYPASS_EN
    assign o_id_bypass_a = slot_hits(r_wb.valid, r_wb.reg_write, r_wb.dest, i_id_rs);
    assign o_id_bypass_b = slot_hits(r_wb.valid, r_wb.reg_write, r_wb.dest, i_id_rt);
`else
    // The register file writes in the first half-cycle, so ID reads see WB data.
`endif

endmodule
